// File: rtl/argmax_seq.sv
// Sequential argmax over M packed popcounts: one neuron compared per clock, start/valid handshake.
// Optional ARGMAX_SNAPSHOT_EN: capture the sums bus at the start edge so the scan ignores later changes.
module argmax_seq #(
    parameter int N = 4,
    parameter int M = 4,
    localparam int SumL = $clog2(N + 1),
    localparam int IdxL = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [M*SumL-1:0]   sums,
    output logic                busy,
    output logic                valid,
    output logic [IdxL-1:0]     class_idx,
    output logic [SumL-1:0]     max_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IdxL-1:0]   ptr_q, ptr_d;
    logic [SumL-1:0]   best_val_q, best_val_d;
    logic [IdxL-1:0]   best_idx_q, best_idx_d;
    logic [IdxL-1:0]   class_idx_q, class_idx_d;
    logic [SumL-1:0]   max_sum_q, max_sum_d;

    logic [M*SumL-1:0] scan_bus;
    logic [SumL-1:0]   live_arr [M];
    logic [SumL-1:0]   scan_arr [M];
    logic [SumL-1:0]   cur_val;
    logic [SumL-1:0]   cand_val;
    logic [IdxL-1:0]   cand_idx;
    logic              start;
    logic              last_ptr;

`ifdef ARGMAX_SNAPSHOT_EN
    logic [M*SumL-1:0] snap_q, snap_d;

    assign scan_bus = snap_q;

    always_comb begin
        snap_d = snap_q;
        if (start) begin
            snap_d = sums;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end
`else
    assign scan_bus = sums;
`endif

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_unpack
            assign live_arr[gi] = sums[gi*SumL +: SumL];
            assign scan_arr[gi] = scan_bus[gi*SumL +: SumL];
        end
    endgenerate

    // Explicit compare-mux avoids a variable index that could exceed the array for non-power-of-two M.
    always_comb begin
        cur_val = scan_arr[0];
        for (int j = 1; j < M; j++) begin
            if (ptr_q == IdxL'(j)) begin
                cur_val = scan_arr[j];
            end
        end
    end

    assign start    = enable && (state_q != SCAN);
    assign last_ptr = (ptr_q == IdxL'(M - 1));

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        cand_val = best_val_q;
        cand_idx = best_idx_q;
        if (cur_val > best_val_q) begin
            cand_val = cur_val;
            cand_idx = ptr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx_q;
        max_sum_d   = max_sum_q;

        case (state_q)
            IDLE, DONE: begin
                if (enable) begin
                    if (M > 1) begin
                        best_val_d = live_arr[0];
                        best_idx_d = '0;
                        ptr_d      = IdxL'(1);
                        state_d    = SCAN;
                    end else begin
                        max_sum_d   = live_arr[0];
                        class_idx_d = '0;
                        state_d     = DONE;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                best_val_d = cand_val;
                best_idx_d = cand_idx;
                if (last_ptr) begin
                    class_idx_d = cand_idx;
                    max_sum_d   = cand_val;
                    state_d     = DONE;
                end else begin
                    ptr_d = ptr_q + IdxL'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            max_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            class_idx_q <= class_idx_d;
            max_sum_q   <= max_sum_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign valid     = (state_q == DONE);
    assign class_idx = class_idx_q;
    assign max_sum   = max_sum_q;

endmodule

// File: tb/tb_argmax_seq.sv
// Directed bench for argmax_seq: M=4 instance for the main scenarios, M=1 instance for the degenerate build.
module tb_argmax_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [11:0] sums;
    logic        busy, valid;
    logic [1:0]  class_idx;
    logic [2:0]  max_sum;

    logic        enable1;
    logic [2:0]  sums1;
    logic        busy1, valid1;
    logic [0:0]  class_idx1;
    logic [2:0]  max_sum1;

    typedef struct {
        int idx;
        int val;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   last_idx = 0;
    int   last_val = 0;

    always #5 clk = ~clk;

    argmax_seq #(.N(4), .M(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sums(sums),
        .busy(busy), .valid(valid), .class_idx(class_idx), .max_sum(max_sum)
    );

    argmax_seq #(.N(5), .M(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .sums(sums1),
        .busy(busy1), .valid(valid1), .class_idx(class_idx1), .max_sum(max_sum1)
    );

    function automatic logic [11:0] pk(input int a0, input int a1, input int a2, input int a3);
        pk = {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pop_cmp(input logic [31:0] obs_idx, input logic [31:0] obs_val);
        res_t r;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("class_idx", obs_idx, r.idx);
            chk("max_sum", obs_val, r.val);
            last_idx = r.idx;
            last_val = r.val;
            $display("result: class_idx=%0d max_sum=%0d (expected %0d/%0d)", obs_idx, obs_val, r.idx, r.val);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge one cycle after the result pulse.
    task automatic run_scan(input logic [11:0] sv, input bit change, input logic [11:0] sv2,
                            input int ei, input int ev);
        int lat;
        sums   = sv;
        enable = 1'b1;
        sb.push_back('{ei, ev});
        @(negedge clk);
        enable = 1'b0;
        if (change) sums = sv2;
        lat = 0;
        while (valid !== 1'b1 && lat < 8) begin
            chk("busy_scan", 32'(busy), 1);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        chk("valid_pulse", 32'(valid), 1);
        chk("busy_done", 32'(busy), 0);
        pop_cmp(32'(class_idx), 32'(max_sum));
        @(negedge clk);
        chk("valid_drop", 32'(valid), 0);
        chk("idx_hold", 32'(class_idx), last_idx);
        chk("sum_hold", 32'(max_sum), last_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_v;
        rst = 1'b1; enable = 1'b0; sums = '0; enable1 = 1'b0; sums1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_idx", 32'(class_idx), 0);
        chk("rst_sum", 32'(max_sum), 0);
        chk("rst_valid1", 32'(valid1), 0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(pk(3, 1, 4, 2), 1'b0, '0, 2, 4);
        run_scan(pk(4, 4, 1, 4), 1'b0, '0, 0, 4);
        run_scan(pk(0, 0, 0, 0), 1'b0, '0, 0, 0);

        // enable held high: a result every 4 cycles, enable inside SCAN has no effect
        sums   = pk(0, 2, 2, 1);
        enable = 1'b1;
        sb.push_back('{1, 2});
        sb.push_back('{1, 2});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_v = (c == 3 || c == 7);
            chk("cont_valid", 32'(valid), 32'(exp_v));
            chk("cont_busy", 32'(busy), 32'(!exp_v));
            if (valid === 1'b1) pop_cmp(32'(class_idx), 32'(max_sum));
            if (c == 7) enable = 1'b0;
        end
        @(negedge clk);
        chk("cont_end_valid", 32'(valid), 0);
        chk("cont_end_busy", 32'(busy), 0);
        chk("cont_end_idx", 32'(class_idx), 1);

        // asynchronous reset in the middle of a scan
        sums   = pk(3, 1, 4, 2);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_idx", 32'(class_idx), 0);
        chk("arst_sum", 32'(max_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        last_idx = 0;
        last_val = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(valid), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        run_scan(pk(1, 0, 0, 3), 1'b0, '0, 3, 3);

        // sums change after the start edge
`ifdef ARGMAX_SNAPSHOT_EN
        run_scan(pk(1, 2, 3, 0), 1'b1, pk(4, 4, 4, 4), 2, 3);
`else
        run_scan(pk(1, 2, 3, 0), 1'b1, pk(4, 4, 4, 4), 1, 4);
`endif

        // single-neuron build
        chk("m1_idle_busy", 32'(busy1), 0);
        sums1   = 3'd5;
        enable1 = 1'b1;
        sb.push_back('{0, 5});
        @(negedge clk);
        enable1 = 1'b0;
        chk("m1_busy", 32'(busy1), 0);
        chk("m1_valid", 32'(valid1), 1);
        pop_cmp(32'(class_idx1), 32'(max_sum1));
        @(negedge clk);
        chk("m1_valid_drop", 32'(valid1), 0);
        chk("m1_busy_after", 32'(busy1), 0);
        chk("m1_sum_hold", 32'(max_sum1), 5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/argmax_seq.md
Name: argmax_seq

Overview:
- Downstream stage of the sequential XNOR-popcount neuron layer.
- Consumes the packed per-neuron popcount bus `sums` (M neurons, SumL bits each) and scans it one neuron per clock.
- Reports the index and value of the largest popcount, i.e. the BNN classification result, with a start/valid handshake.

Parameters:
- N, 4, input vector width of the upstream layer; sets popcount width.
- M, 4, number of neurons/classes scanned; M >= 1.
- SumL, $clog2(N+1), bits per popcount (derived localparam, not overridable).
- IdxL, (M>1 ? $clog2(M) : 1), class index width (derived localparam).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  start request, sampled on rising clk.
- sums  input  M*SumL  packed popcounts; neuron j at bits [j*SumL +: SumL], unsigned.
- busy  output  1  high while a scan is in progress.
- valid  output  1  one-cycle pulse, result available.
- class_idx  output  IdxL  index of winning neuron.
- max_sum  output  SumL  popcount of winning neuron.

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, valid=0, class_idx=0, max_sum=0; internal pointer and best registers cleared.
- States: IDLE, SCAN, DONE. busy=1 only in SCAN. valid=1 only in DONE.
- Start acceptance: enable is accepted only in IDLE or DONE. It is ignored in SCAN, with no restart and no queueing.
- Edge k, enable=1, M>1:
  - best_val <= sums[0], best_idx <= 0, ptr <= 1.
  - Go to SCAN.
- Edge k, enable=1, M=1:
  - max_sum <= sums[0], class_idx <= 0.
  - Go directly to DONE.
- SCAN, each edge:
  - If sums[ptr] > best_val (strict, unsigned), then best_val <= sums[ptr] and best_idx <= ptr.
  - ptr increments.
  - On the edge where ptr==M-1 is compared, class_idx/max_sum load the final best and state goes to DONE.
- Latency: enable sampled at edge k makes valid=1 in the cycle after edge k+M-1 (M=4: after edge k+3). valid lasts exactly one cycle.
- DONE, next edge:
  - enable=1: new start, same as the IDLE start; valid drops.
  - Otherwise: go to IDLE.
- Back-to-back starts therefore give one result every M cycles.
- class_idx/max_sum hold their value from DONE until the next DONE or reset. They do not change mid-scan; best_* are internal.
- Tie-break: the lowest index wins. Equal later values never replace.
- All-equal input (including all zero): class_idx=0, max_sum=that value.
- Input stability: without the optional feature, sums must be held stable from edge k through the final SCAN edge. Sampled values are used as-is.
- Reset mid-scan: immediate return to IDLE with all outputs zero. No valid is produced for the aborted scan.
- ptr never exceeds M-1. No wrap-around is reachable.

Optional Feature:
- Macro: ARGMAX_SNAPSHOT_EN.
- When defined:
  - At the accepted start edge, the full sums bus is copied into an internal M*SumL snapshot register.
  - The scan reads only the snapshot, so sums may change freely after the start edge.
  - The snapshot is cleared by reset. Latency is unchanged.
- When undefined:
  - No snapshot register; the scan reads live sums.
  - The stability requirement above applies.

Test Plan:
- N=4, M=4, sums {j0..j3}={3,1,4,2}, enable pulse at edge k -> busy=1 for edges k..k+2; valid=1 one cycle after edge k+3; class_idx=2, max_sum=4; outputs hold afterwards.
- Ties {4,4,1,4} -> class_idx=0, max_sum=4. All-zero {0,0,0,0} -> class_idx=0, max_sum=0, valid still pulses.
- enable held high continuously with {0,2,2,1} -> results 1/2 every 4 cycles; enable during SCAN does not restart or lengthen the scan.
- rst asserted asynchronously mid-SCAN (between edges) -> busy, valid, class_idx, max_sum all 0 immediately; no valid until the next enable; the next scan of {1,0,0,3} gives 3/3.
- ARGMAX_SNAPSHOT_EN defined: start with {1,2,3,0}, then drive sums={4,4,4,4} from edge k+1 -> result class_idx=2, max_sum=3. Undefined, with {4,4,4,4} driven from edge k+1 -> class_idx=1, max_sum=4.
- M=1 build (sums=3'd5) -> valid one cycle after the enable edge, class_idx=0, max_sum=5, busy never asserted.
